custom_mode_ctrl: RTL and testbench
===================================

# custom_mode_ctrl

Initiator-side controller for the `Top_Custom_mode` 2x2 engine. It accepts a job request and drives the engine's enable, then waits for `custom_mode_done`. It captures `c11..c22` into a result register, presents that register on a valid/ready port, and re-resets the engine so the next job starts cleanly. It sits between the host/system sequencer and the engine, replacing the manual enable/done/reset sequencing done by bench code today.

## Interface
Parameters:
- `DATA_W`, 8: width of each result element.
- `RST_CYC`, 3: cycles `eng_rst` is held after each job (minimum 1).
- `TIMEOUT_CYC`, 255: maximum RUN cycles before abort. Used only with `CUSTOM_CTRL_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: job request. Level-sampled in IDLE.
- `busy`, out, 1: high whenever state is not IDLE.
- `eng_rst`, out, 1: active-high reset to the engine's `rst`.
- `eng_en`, out, 1: drives the engine's `custom_mode_en`.
- `eng_done`, in, 1: engine's `custom_mode_done`.
- `eng_c11`, `eng_c12`, `eng_c21`, `eng_c22`, in, `DATA_W` each: engine results.
- `res_valid`, out, 1: result word available.
- `res_ready`, in, 1: downstream accepts the result.
- `res_data`, out, `4*DATA_W`: packed as {c11, c12, c21, c22}, with c11 in the MSBs.
- `timeout_err`, out, 1: sticky abort flag.

## Operation
- States: IDLE, RUN, RECOVER.
- IDLE: `eng_rst`=1, `eng_en`=0.
  - Go to RUN when `start` && !(`res_valid` && !`res_ready`).
  - A result word being handed off in the same cycle does not block the start.
  - On accepting a start, clear `timeout_err` and the run counter.
- RUN: `eng_rst`=0, `eng_en`=1. The run counter increments each cycle.
  - On sampling `eng_done`=1: load `res_data` from `eng_c*`, set `res_valid`, go to RECOVER.
  - `eng_done` outside RUN is ignored.
- RECOVER: `eng_rst`=1, `eng_en`=0. Hold for exactly `RST_CYC` cycles, then go to IDLE.
- Result port:
  - `res_valid` stays high until a cycle with `res_ready`=1. It clears on that edge.
  - `res_data` is stable while `res_valid`=1. It keeps its last value after the handoff.
- `start` while busy is ignored, not queued.
- All outputs are registered. No combinational path from any input to any output.
- Async reset (`rst`=0):
  - State goes to IDLE.
  - Outputs: `eng_rst`=1, `eng_en`=0, `busy`=0, `res_valid`=0, `res_data`=0, `timeout_err`=0.
  - Counters are cleared.
  - Asserting reset mid-RUN drops `eng_en` immediately. It does not wait for a clock.

## Timing
- `start` is sampled high at edge E0. At E0+1 cycle: `eng_en`=1, `eng_rst`=0, `busy`=1.
- `eng_done` is sampled high at edge Ek. At Ek+1: `res_valid`=1, `eng_en`=0, `eng_rst`=1.
  - This matches the engine's expected reset-one-cycle-after-done sequence.
- RECOVER lasts `RST_CYC` cycles. `busy` falls on the cycle IDLE is entered.
- The earliest restart is one cycle after IDLE is entered.
- Minimum job overhead: 1 cycle to start, plus 1 cycle for done capture, plus `RST_CYC`.

## Configuration
- `CUSTOM_CTRL_TIMEOUT_EN` defined:
  - In RUN, when the run counter reaches `TIMEOUT_CYC` with `eng_done`=0: set `timeout_err`=1 and go to RECOVER.
  - No result is written and `res_valid` is not set.
  - If `eng_done`=1 in the same cycle the counter reaches `TIMEOUT_CYC`, done wins: normal capture, no error.
- `CUSTOM_CTRL_TIMEOUT_EN` not defined:
  - RUN waits indefinitely.
  - `timeout_err` is tied to 0.
  - The run counter and its compare logic are removed.

## Structure
- Shared package `custom_mode_pkg` holds:
  - the state enum (IDLE/RUN/RECOVER);
  - the `DATA_W` default;
  - the `RES_W` = 4*`DATA_W` constant;
  - the packing-order localparams for c11..c22.
- No sub-module. A single counter is reused for the RUN timeout and the RECOVER length, and it is reloaded on each state entry.

## Test plan
- **Basic job:** hold `start`=1 for 1 cycle. The engine model asserts done 6 cycles after `eng_en` rises, with c11=8'h13, c12=8'h16, c21=8'h2B, c22=8'h32. Required response:
  - `res_valid` rises one cycle after done;
  - `res_data`=32'h13162B32;
  - `eng_rst` is high for 3 cycles;
  - `busy` falls 3 cycles after done capture.
- **Backpressure:** hold `res_ready`=0 after job 1 and pulse `start`. Required response:
  - the start is ignored in IDLE, and `eng_en` stays 0;
  - after `res_ready`=1 for 1 cycle, `res_valid` drops;
  - a `start` in that same cycle begins job 2.
- **Start while busy:** assert `start` during RUN and during RECOVER. Required response: no second job, and exactly one `res_valid` pulse sequence.
- **Timeout (macro on, `TIMEOUT_CYC`=10):** the engine never asserts done. Required response:
  - `timeout_err`=1 after 10 RUN cycles;
  - `eng_en` is 0 the next cycle and `res_valid` stays 0;
  - the next accepted `start` clears `timeout_err`.
- **Done at the timeout boundary:** assert done exactly on RUN cycle 10. Required response: the result is captured and `timeout_err` stays 0.
- **Async reset mid-RUN:** drive `rst`=0 between clock edges, 3 cycles into RUN. Required response:
  - `eng_en`=0 and `eng_rst`=1 immediately;
  - `busy`=0, `res_valid`=0, `res_data`=0.

Source files
------------

// File: rtl/custom_mode_pkg.sv
// custom_mode_pkg: shared state encoding, default widths and result packing order for custom_mode_ctrl
package custom_mode_pkg;
  typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;
  localparam int CM_DATA_W = 8;
  localparam int CM_RES_W = 4 * CM_DATA_W;
  localparam int C11_POS = 3;
  localparam int C12_POS = 2;
  localparam int C21_POS = 1;
  localparam int C22_POS = 0;
endpackage

// File: rtl/custom_mode_ctrl.sv
// custom_mode_ctrl: start/run/capture/re-reset sequencer for the Top_Custom_mode engine.
// Optional RUN watchdog enabled by defining CUSTOM_CTRL_TIMEOUT_EN.
module custom_mode_ctrl
  import custom_mode_pkg::*;
#(
  parameter int DATA_W = CM_DATA_W,
  parameter int RST_CYC = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                eng_rst,
  output logic                eng_en,
  input  logic                eng_done,
  input  logic [DATA_W-1:0]   eng_c11,
  input  logic [DATA_W-1:0]   eng_c12,
  input  logic [DATA_W-1:0]   eng_c21,
  input  logic [DATA_W-1:0]   eng_c22,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DATA_W-1:0] res_data,
  output logic                timeout_err
);
  localparam int CNT_MAX = TIMEOUT_CYC > RST_CYC ? TIMEOUT_CYC : RST_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
`ifdef CUSTOM_CTRL_TIMEOUT_EN
  localparam bit RUN_CNT = 1'b1;
`else
  localparam bit RUN_CNT = 1'b0;
`endif
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic accept, capture, expire;
  assign accept = state == IDLE && start && !(res_valid && !res_ready);
  assign capture = state == RUN && eng_done;
`ifdef CUSTOM_CTRL_TIMEOUT_EN
  assign expire = state == RUN && !eng_done && cnt == CNT_W'(TIMEOUT_CYC);
`else
  assign expire = 1'b0;
`endif
  // cnt counts cycles spent in the current state, starting at 1 on entry
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (capture || expire) state_nx = RECOVER;
    else if (state == RECOVER && cnt == CNT_W'(RST_CYC)) state_nx = IDLE;
    cnt_nx = state_nx != state ? CNT_W'(1)
           : (state == RECOVER || (RUN_CNT && state == RUN)) ? cnt + CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      eng_rst <= 1'b1;
      eng_en <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      busy <= state_nx != IDLE;
      eng_rst <= state_nx != RUN;
      eng_en <= state_nx == RUN;
      res_valid <= capture || (res_valid && !res_ready);
      if (capture) begin
        res_data[C11_POS*DATA_W +: DATA_W] <= eng_c11;
        res_data[C12_POS*DATA_W +: DATA_W] <= eng_c12;
        res_data[C21_POS*DATA_W +: DATA_W] <= eng_c21;
        res_data[C22_POS*DATA_W +: DATA_W] <= eng_c22;
      end
    end
  end
`ifdef CUSTOM_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timeout_err <= 1'b0;
    else timeout_err <= expire || (timeout_err && !accept);
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_custom_mode_ctrl.sv
// tb_custom_mode_ctrl: randomized job-level checks of custom_mode_ctrl against spec timing rules
module tb_custom_mode_ctrl;
  localparam int RST_CYC = 3;
  localparam int TO_CYC = 10;
`ifdef CUSTOM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, eng_done = 1'b0, res_ready = 1'b0;
  logic [7:0] eng_c11 = '0, eng_c12 = '0, eng_c21 = '0, eng_c22 = '0;
  logic busy, eng_rst, eng_en, res_valid, timeout_err;
  logic [31:0] res_data;
  logic exp_rv = 1'b0, exp_terr = 1'b0;
  logic [31:0] exp_data = '0;
  int total = 0, bad = 0;

  custom_mode_ctrl #(.DATA_W(8), .RST_CYC(RST_CYC), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .eng_rst(eng_rst), .eng_en(eng_en),
    .eng_done(eng_done), .eng_c11(eng_c11), .eng_c12(eng_c12), .eng_c21(eng_c21),
    .eng_c22(eng_c22), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string ph, input logic en, input logic bsy);
    chk({ph, "_en"}, eng_en, en);
    chk({ph, "_erst"}, eng_rst, !en);
    chk({ph, "_busy"}, busy, bsy);
    chk({ph, "_rv"}, res_valid, exp_rv);
    chk({ph, "_data"}, res_data, exp_data);
    chk({ph, "_terr"}, timeout_err, exp_terr);
  endtask

  // one job: idle until an accepted start, lat RUN cycles (done on the last), then recovery
  task automatic job(input int lat, input logic [31:0] d, input int bp);
    int g = 0;
    int n;
    bit acc, to;
    do begin
      start = g < bp ? 1'b1 : g >= bp + 6 ? 1'b1 : 1'($urandom_range(0, 1));
      res_ready = g < bp ? 1'b0 : g >= bp + 6 ? 1'b1 : 1'($urandom_range(0, 1));
      eng_done = 1'($urandom_range(0, 1));
      acc = start && !(exp_rv && !res_ready);
      if (res_ready) exp_rv = 1'b0;
      if (acc) exp_terr = 1'b0;
      tick();
      g++;
      chk_all("idle", acc, acc);
    end while (!acc);
    to = TO_EN && lat > TO_CYC;
    n = to ? TO_CYC : lat;
    for (int i = 1; i <= n; i++) begin
      eng_done = !to && i == lat;
      {eng_c11, eng_c12, eng_c21, eng_c22} = eng_done ? d : $urandom;
      start = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
      if (eng_done) begin
        exp_rv = 1'b1;
        exp_data = d;
      end
      if (to && i == n) exp_terr = 1'b1;
      tick();
      chk_all("run", i < n, 1'b1);
    end
    for (int r = 1; r <= RST_CYC; r++) begin
      start = 1'($urandom_range(0, 1));
      eng_done = 1'($urandom_range(0, 1));
      {eng_c11, eng_c12, eng_c21, eng_c22} = $urandom;
      res_ready = 1'($urandom_range(0, 1));
      if (res_ready) exp_rv = 1'b0;
      tick();
      chk_all("rec", 1'b0, r < RST_CYC);
    end
    start = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_all("reset", 1'b0, 1'b0);
    rst = 1'b1;
    job(6, 32'h13162B32, 0);
    job(4, $urandom, 5);
    job(TO_CYC, 32'hA5A55A5A, 0);
    job(TO_CYC + 30, 32'hDEADBEEF, 3);
    job(TO_CYC + 1, $urandom, 0);
    job(3, $urandom, 2);
    for (int k = 0; k < 25; k++) job($urandom_range(1, 14), $urandom, $urandom_range(0, 3));
    start = 1'b1;
    res_ready = 1'b1;
    eng_done = 1'b0;
    exp_rv = 1'b0;
    exp_terr = 1'b0;
    tick();
    chk_all("pre_abort", 1'b1, 1'b1);
    start = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    exp_data = '0;
    chk_all("abort", 1'b0, 1'b0);
    #2 rst = 1'b1;
    job(5, $urandom, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=%0d exp=%0d", 0, 1);
    $fatal(1, "watchdog expired");
  end
endmodule
